uart_rx_cfg: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver in the UART path. It adds:
- configurable data width, parity mode and stop-bit count;
- 3-sample majority voting at mid-bit;
- false-start rejection;
- parity, framing and break error reporting.

It sits between the board RX pin and the command/register-write parser of the video capture pipeline. It runs in the single system clock domain.

---
 rtl/uart_rx_cfg.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/PARITY/STOP_BITS frames with 3-sample mid-bit voting,
// false-start rejection and parity/framing/break reporting.
module uart_rx_cfg #(
    parameter logic [15:0] BPS_NUM   = 16'd434,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_det_o,
    output logic                 busy_o
);

    localparam logic [15:0] Mid      = BPS_NUM >> 1;
    localparam logic [15:0] MidP1    = Mid + 16'd1;
    localparam logic [3:0]  LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LastStop = 4'(STOP_BITS - 1);
    localparam logic        OddPar   = (PARITY == 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StDone, StWaitHigh
    } state_e;

    state_e state_q, state_d;

    logic                 meta_q, sync_q, hist_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 brk_out_q, brk_out_d;

    logic vote, at_vote, at_end, ferr_now;

    // Samples at M-1 and M are held in samp_q; the third comes from sync at M+1.
    assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync_q) | (samp_q[0] & sync_q);
    assign at_vote = (cnt_q == MidP1);
    assign at_end  = (cnt_q == BPS_NUM);
    assign ferr_now = ferr_q | (at_vote & ~vote);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!sync_q) state_d = StStart;
            StStart: begin
                if (at_vote && vote) begin
                    state_d = StIdle;
                end else if (at_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_end && (bit_q == LastData)) begin
                    state_d = (PARITY != 0) ? StParity : StStop;
                end
            end
            StParity:   if (at_end) state_d = StStop;
            StStop:     if (at_vote && (bit_q == LastStop)) state_d = StDone;
            StDone:     state_d = ferr_q ? StWaitHigh : StIdle;
            StWaitHigh: if (sync_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        pbit_d     = pbit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_out_d  = brk_out_q;

        if ((state_d != state_q) || (state_q == StIdle) || (state_q == StDone)
            || (state_q == StWaitHigh) || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (state_d != state_q) begin
            bit_d = '0;
        end else if (((state_q == StData) || (state_q == StStop)) && at_end) begin
            bit_d = bit_q + 4'd1;
        end

        if (cnt_q == Mid) begin
            samp_d = {hist_q, sync_q};
        end

        if (state_q == StIdle) begin
            pbit_d = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
        end

        if (at_vote) begin
            unique case (state_q)
                StData:   shift_d = {vote, shift_q[DATA_BITS-1:1]};
                StParity: begin
                    pbit_d = vote;
                    perr_d = vote ^ (^shift_q) ^ OddPar;
                end
                StStop:   ferr_d = ferr_now;
                default:  ;
            endcase
        end

        // Result registers load on the way into DONE so they are valid with rx_valid.
        if ((state_q == StStop) && (state_d == StDone)) begin
            data_out_d = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_now;
            brk_out_d  = ferr_now && (shift_q == '0) && !pbit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            hist_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            pbit_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
        end else begin
            meta_q     <= uart_rx_i;
            sync_q     <= meta_q;
            hist_q     <= sync_q;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            pbit_q     <= pbit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_out_q <= data_out_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_out_q  <= brk_out_d;
        end
    end

    // Outputs
    always_comb begin
        rx_valid_o   = (state_q == StDone);
        busy_o       = (state_q != StIdle);
        rx_data_o    = data_out_q;
        parity_err_o = perr_out_q;
        frame_err_o  = ferr_out_q;
        break_det_o  = brk_out_q;
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three builds (8N1, 8E1, 7O2) driven with directed and
// random frames; a frame-level decoder model predicts each rx_valid.
module tb_uart_rx_cfg;

    localparam logic [15:0] Bps    = 16'd31;
    localparam int          BitClk = 32;
    localparam int          Mid    = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;
    int unsigned cyc = 0;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] vld, perr, ferr, brk, busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.BPS_NUM(Bps), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_line[0]), .rx_data_o(d0), .rx_valid_o(vld[0]),
        .parity_err_o(perr[0]), .frame_err_o(ferr[0]), .break_det_o(brk[0]), .busy_o(busy[0])
    );
    uart_rx_cfg #(.BPS_NUM(Bps), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_line[1]), .rx_data_o(d1), .rx_valid_o(vld[1]),
        .parity_err_o(perr[1]), .frame_err_o(ferr[1]), .break_det_o(brk[1]), .busy_o(busy[1])
    );
    uart_rx_cfg #(.BPS_NUM(Bps), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_line[2]), .rx_data_o(d2), .rx_valid_o(vld[2]),
        .parity_err_o(perr[2]), .frame_err_o(ferr[2]), .break_det_o(brk[2]), .busy_o(busy[2])
    );

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t sb [3][$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   busy_pend [3];
    int unsigned pulse_cyc [3];

    function automatic int nbits(input int d);
        return (d == 2) ? 7 : 8;
    endfunction
    function automatic int npar(input int d);   // 0 none, 1 odd, 2 even
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction
    function automatic int nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction
    function automatic logic [8:0] get_data(input int d);
        case (d)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return {2'b0, d2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid must match the oldest outstanding prediction.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (busy_pend[d]) begin
                    busy_pend[d] = 1'b0;
                    check($sformatf("busy_after_pulse_%0d", d), 32'(busy[d]), 0);
                end
                if (vld[d]) begin
                    pulse_cyc[d] = cyc;
                    if (sb[d].size() == 0) begin
                        check($sformatf("unexpected_pulse_%0d", d), 32'(vld[d]), 0);
                    end else begin
                        mon_e = sb[d].pop_front();
                        check($sformatf("data_%0d", d), 32'(get_data(d)), 32'(mon_e.data));
                        check($sformatf("parity_err_%0d", d), 32'(perr[d]), 32'(mon_e.perr));
                        check($sformatf("frame_err_%0d", d), 32'(ferr[d]), 32'(mon_e.ferr));
                        check($sformatf("break_det_%0d", d), 32'(brk[d]), 32'(mon_e.brk));
                        if (!mon_e.ferr) busy_pend[d] = 1'b1;
                    end
                end
            end
        end
    end

    // Build the line levels of one frame; flip corrupts the parity bit.
    task automatic build(input int d, input logic [8:0] data, input bit flip,
                         input logic [1:0] stops, output bit q[$]);
        bit p;
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < nbits(d); i++) q.push_back(data[i]);
        if (npar(d) != 0) begin
            p = ($countones(data[7:0] & 8'((1 << nbits(d)) - 1)) % 2) == 1;
            if (npar(d) == 1) p = ~p;
            q.push_back(p ^ flip);
        end
        for (int s = 0; s < nstop(d); s++) q.push_back(stops[s]);
    endtask

    // Reference decoder: what a receiver should report for this sequence of bit levels.
    task automatic model(input int d, input bit q[$]);
        exp_t e;
        int   pos;
        int   ones;
        bit   pbit;
        e = '0;
        for (int i = 0; i < nbits(d); i++) e.data[i] = q[1 + i];
        pos  = 1 + nbits(d);
        pbit = 1'b0;
        if (npar(d) != 0) begin
            pbit = q[pos];
            ones = $countones(e.data) + int'(pbit);
            e.perr = (npar(d) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            pos++;
        end
        for (int s = 0; s < nstop(d); s++) if (!q[pos + s]) e.ferr = 1'b1;
        e.brk = e.ferr && (e.data == 0) && !pbit;
        sb[d].push_back(e);
    endtask

    task automatic drive(input int d, input bit q[$], input int glitch_bit, input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            for (int c = 0; c < BitClk; c++) begin
                rx_line[d] = (i == glitch_bit && c == Mid) ? ~q[i] : q[i];
                @(negedge clk);
            end
        end
    endtask

    task automatic send(input int d, input logic [8:0] data, input bit flip,
                        input logic [1:0] stops, input int gap);
        bit q[$];
        build(d, data, flip, stops, q);
        model(d, q);
        drive(d, q, -1, 99);
        rx_line[d] = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (sb[d].size() != 0 && n < 16 * BitClk) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_outstanding_%0d", d), 32'(sb[d].size()), 0);
    endtask

    initial begin
        bit          q[$];
        int unsigned t0;
        int          lat;
        int          n;
        logic [1:0]  stops;
        bit          flip;
        logic [8:0]  data;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_outputs_%0d", d),
                  32'({get_data(d), vld[d], perr[d], ferr[d], brk[d], busy[d]}), 0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 8N1 frame plus latency window
        t0 = cyc;
        send(0, 9'h55, 1'b0, 2'b11, 2 * BitClk);
        drain(0);
        lat = int'(pulse_cyc[0] - (t0 + 1));
        checks++;
        if (lat < 306 || lat > 308) begin
            errors++;
            $display("FAIL latency: got %0d clocks, expected 307 +/- 1", lat);
        end

        // Even parity good and corrupted
        send(1, 9'h0A3, 1'b0, 2'b11, BitClk);
        send(1, 9'h0A3, 1'b1, 2'b11, BitClk);
        drain(1);

        // Stop bit low, then line held low: exactly one pulse
        for (int d = 0; d < 3; d++) begin
            build(d, 9'h03C, 1'b0, 2'b00, q);
            model(d, q);
            drive(d, q, -1, 99);
            rx_line[d] = 1'b0;
            repeat (3 * BitClk) @(negedge clk);
            rx_line[d] = 1'b1;
            repeat (2 * BitClk) @(negedge clk);
            drain(d);
        end

        // Break: 12 bit times low, then a clean frame
        for (int d = 0; d < 3; d++) begin
            q = {};
            for (int i = 0; i < 12; i++) q.push_back(1'b0);
            model(d, q);
            drive(d, q, -1, 99);
            rx_line[d] = 1'b1;
            repeat (2 * BitClk) @(negedge clk);
            send(d, 9'h07E, 1'b0, 2'b11, BitClk);
            drain(d);
        end

        // Short low glitch on idle line is rejected
        rx_line[0] = 1'b0;
        repeat (7) @(negedge clk);
        rx_line[0] = 1'b1;
        n = 0;
        while (busy[0] && n < int'(Bps)) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_clear", 32'(busy[0]), 0);
        repeat (2 * BitClk) @(negedge clk);

        // One-clock glitch inside data bit 3 is voted out
        for (int d = 0; d < 3; d++) begin
            build(d, 9'h0F0 & 9'((1 << nbits(d)) - 1), 1'b0, 2'b11, q);
            model(d, q);
            drive(d, q, 4, 99);
            rx_line[d] = 1'b1;
            repeat (BitClk) @(negedge clk);
            drain(d);
        end

        // Back-to-back 7O2 frames with no idle gap
        send(2, 9'h012, 1'b0, 2'b11, 0);
        send(2, 9'h034, 1'b0, 2'b11, BitClk);
        drain(2);

        // Reset in the middle of a frame: outputs clear, no pulse, next frame fine
        build(1, 9'h05A, 1'b0, 2'b11, q);
        drive(1, q, -1, 4);
        repeat (BitClk / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              32'({get_data(1), vld[1], perr[1], ferr[1], brk[1], busy[1]}), 0);
        rx_line[1] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BitClk) @(negedge clk);
        send(1, 9'h05A, 1'b0, 2'b11, BitClk);
        drain(1);

        // Random frames
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 25; k++) begin
                data  = 9'($urandom) & 9'((1 << nbits(d)) - 1);
                flip  = (npar(d) != 0) && ($urandom_range(0, 3) == 0);
                stops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
                if (stops[0] && (nstop(d) == 1 || stops[1])) begin
                    send(d, data, flip, stops, $urandom_range(0, 40));
                end else begin
                    send(d, data, flip, stops, $urandom_range(4, 40));
                end
            end
            drain(d);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
